// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the leaky integrate-and-fire layer.
// Potential arithmetic is done in 32-bit int, so POT_W must stay at or below 30.
package snn_pkg;

    localparam int DEF_N_IN    = 2;
    localparam int DEF_N_OUT   = 1;
    localparam int DEF_W_W     = 4;
    localparam int DEF_POT_W   = 12;
    localparam int DEF_TH_W    = 8;
    localparam int DEF_LEAK    = 0;
    localparam int DEF_REFRAC  = 2;
    localparam int DEF_W_INIT  = 1;
    localparam int DEF_TH_INIT = 4;

    // Per-input contribution sign: +1, -1 or 0 (both or neither line high).
    typedef enum logic [1:0] {
        IN_ZERO = 2'b00,
        IN_POS  = 2'b01,
        IN_NEG  = 2'b10
    } in_val_e;

    function automatic in_val_e encode_in(input logic p, input logic n);
        if (p && !n)      return IN_POS;
        else if (n && !p) return IN_NEG;
        else              return IN_ZERO;
    endfunction

    // a + b clamped to the signed range of a w-bit value.
    function automatic int sat_add(input int a, input int b, input int w);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

    // Move v toward zero by l without crossing zero.
    function automatic int leak_to_zero(input int v, input int l);
        if (v > 0)      return (v > l) ? v - l : 0;
        else if (v < 0) return (v < -l) ? v + l : 0;
        else            return 0;
    endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// One LIF neuron: its weight row, threshold, potential register and
// refractory counter. Config writes land at the edge, so the integrate
// in the same cycle still sees the old weights/threshold.
module snn_lif_neuron
    import snn_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int W_W     = DEF_W_W,
    parameter int POT_W   = DEF_POT_W,
    parameter int TH_W    = DEF_TH_W,
    parameter int LEAK    = DEF_LEAK,
    parameter int REFRAC  = DEF_REFRAC,
    parameter int W_INIT  = DEF_W_INIT,
    parameter int TH_INIT = DEF_TH_INIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic [2*N_IN-1:0] in_code_i,
    input  logic [N_IN-1:0]   w_we_i,
    input  logic [W_W-1:0]    w_data_i,
    input  logic              th_we_i,
    input  logic [TH_W-1:0]   th_data_i,
    output logic              spike_o,
    output logic [POT_W-1:0]  pot_o
);

    localparam int DW = W_W + $clog2(N_IN) + 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic signed [W_W-1:0]   w_q [N_IN];
    logic [TH_W-1:0]         th_q;
    logic signed [POT_W-1:0] v_q, v_d;
    logic [RW-1:0]           refr_q, refr_d;
    logic                    spike_q, spike_d;
    logic signed [DW-1:0]    delta;
    int                      v_sum;
    int                      v_leak;
    logic                    fire;

    // Weight row and threshold: reset to init values, otherwise written on strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_IN; i++) w_q[i] <= W_W'(W_INIT);
            th_q <= TH_W'(TH_INIT);
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (w_we_i[i]) w_q[i] <= w_data_i;
            end
            if (th_we_i) th_q <= th_data_i;
        end
    end

    // Weighted input sum at full width, so it cannot overflow before saturation.
    always_comb begin
        delta = '0;
        for (int i = 0; i < N_IN; i++) begin
            case (in_val_e'(in_code_i[2*i +: 2]))
                IN_POS:  delta = delta + DW'(w_q[i]);
                IN_NEG:  delta = delta - DW'(w_q[i]);
                default: ;
            endcase
        end
    end

    // Integrate, leak, fire; clr beats refractory, which beats integration.
    always_comb begin
        v_sum   = sat_add(int'(v_q), int'(delta), POT_W);
        v_leak  = leak_to_zero(v_sum, LEAK);
        fire    = (th_q != '0) && (v_leak >= int'({1'b0, th_q}));
        v_d     = v_q;
        refr_d  = refr_q;
        spike_d = 1'b0;
        if (clr_i) begin
            v_d    = '0;
            refr_d = '0;
        end else if (refr_q != '0) begin
            v_d    = '0;
            refr_d = refr_q - RW'(1);
        end else if (fire) begin
            v_d     = '0;
            refr_d  = RW'(REFRAC);
            spike_d = 1'b1;
        end else begin
            v_d = v_leak[POT_W-1:0];
        end
    end

    // Potential, refractory and spike registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q     <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;
    assign pot_o   = v_q;

endmodule

// File: rtl/snn_lif_layer.sv
// Fully connected layer of N_OUT LIF neurons over N_IN bipolar spike inputs.
// This level only encodes the inputs and decodes config writes; out-of-range
// neuron/synapse indices match no neuron and are therefore dropped.
module snn_lif_layer
    import snn_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int W_W     = DEF_W_W,
    parameter int POT_W   = DEF_POT_W,
    parameter int TH_W    = DEF_TH_W,
    parameter int LEAK    = DEF_LEAK,
    parameter int REFRAC  = DEF_REFRAC,
    parameter int W_INIT  = DEF_W_INIT,
    parameter int TH_INIT = DEF_TH_INIT
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_IN-1:0]                         p_in,
    input  logic [N_IN-1:0]                         n_in,
    input  logic                                    cfg_w_we,
    input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] cfg_nrn,
    input  logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0]   cfg_syn,
    input  logic [W_W-1:0]                          cfg_w,
    input  logic                                    cfg_th_we,
    input  logic [TH_W-1:0]                         cfg_th,
    input  logic                                    clr,
    output logic [N_OUT-1:0]                        spike_out,
    output logic [N_OUT*POT_W-1:0]                  pot_out
);

    logic [2*N_IN-1:0] in_code;

    // Encode each p/n pair into a signed contribution code.
    always_comb begin
        in_code = '0;
        for (int i = 0; i < N_IN; i++) in_code[2*i +: 2] = encode_in(p_in[i], n_in[i]);
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_nrn
        logic [N_IN-1:0] w_we;
        logic            th_we;
        logic            nrn_hit;

        // Config strobes addressed to this neuron.
        always_comb begin
            nrn_hit = (int'(cfg_nrn) == j);
            th_we   = cfg_th_we && nrn_hit;
            for (int i = 0; i < N_IN; i++) w_we[i] = cfg_w_we && nrn_hit && (int'(cfg_syn) == i);
        end

        snn_lif_neuron #(
            .N_IN   (N_IN),
            .W_W    (W_W),
            .POT_W  (POT_W),
            .TH_W   (TH_W),
            .LEAK   (LEAK),
            .REFRAC (REFRAC),
            .W_INIT (W_INIT),
            .TH_INIT(TH_INIT)
        ) u_nrn (
            .clk_i    (clk),
            .rst_i    (rst),
            .clr_i    (clr),
            .in_code_i(in_code),
            .w_we_i   (w_we),
            .w_data_i (cfg_w),
            .th_we_i  (th_we),
            .th_data_i(cfg_th),
            .spike_o  (spike_out[j]),
            .pot_o    (pot_out[j*POT_W +: POT_W])
        );
    end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Bench for snn_lif_layer: three instances share stimulus (A: defaults,
// B: LEAK=1, C: POT_W=6/TH_W=4). An integer reference model of all three is
// stepped every clock; directed tables add literal expectations on top.
module tb_snn_lif_layer;

    logic       clk = 1'b0;
    logic       rst, clr, cfg_w_we, cfg_th_we;
    logic [1:0] p_in, n_in;
    logic [0:0] cfg_nrn, cfg_syn;
    logic [3:0] cfg_w;
    logic [7:0] cfg_th;
    logic [0:0] spk_a, spk_b, spk_c;
    logic [11:0] pot_a, pot_b;
    logic [5:0]  pot_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snn_lif_layer dut_a (
        .clk(clk), .rst(rst), .p_in(p_in), .n_in(n_in), .cfg_w_we(cfg_w_we),
        .cfg_nrn(cfg_nrn), .cfg_syn(cfg_syn), .cfg_w(cfg_w), .cfg_th_we(cfg_th_we),
        .cfg_th(cfg_th), .clr(clr), .spike_out(spk_a), .pot_out(pot_a)
    );

    snn_lif_layer #(.LEAK(1)) dut_b (
        .clk(clk), .rst(rst), .p_in(p_in), .n_in(n_in), .cfg_w_we(cfg_w_we),
        .cfg_nrn(cfg_nrn), .cfg_syn(cfg_syn), .cfg_w(cfg_w), .cfg_th_we(cfg_th_we),
        .cfg_th(cfg_th), .clr(clr), .spike_out(spk_b), .pot_out(pot_b)
    );

    snn_lif_layer #(.POT_W(6), .TH_W(4)) dut_c (
        .clk(clk), .rst(rst), .p_in(p_in), .n_in(n_in), .cfg_w_we(cfg_w_we),
        .cfg_nrn(cfg_nrn), .cfg_syn(cfg_syn), .cfg_w(cfg_w), .cfg_th_we(cfg_th_we),
        .cfg_th(cfg_th[3:0]), .clr(clr), .spike_out(spk_c), .pot_out(pot_c)
    );

    // ---------------- reference model ----------------
    int m_w[3][2];
    int m_th[3];
    int m_v[3];
    int m_refr[3];
    int m_spk[3];
    int m_leak[3]   = '{0, 1, 0};
    int m_potw[3]   = '{12, 12, 6};
    int m_thmask[3] = '{255, 255, 15};

    function automatic int in_val(input int i);
        if (p_in[i] && !n_in[i]) return 1;
        if (n_in[i] && !p_in[i]) return -1;
        return 0;
    endfunction

    task automatic model_step();
        int d, s, hi, lo, wv;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_w[k][0] = 1; m_w[k][1] = 1; m_th[k] = 4;
                m_v[k] = 0; m_refr[k] = 0; m_spk[k] = 0;
                continue;
            end
            d = in_val(0) * m_w[k][0] + in_val(1) * m_w[k][1];
            m_spk[k] = 0;
            if (clr) begin
                m_v[k] = 0; m_refr[k] = 0;
            end else if (m_refr[k] > 0) begin
                m_v[k] = 0; m_refr[k] = m_refr[k] - 1;
            end else begin
                hi = (1 << (m_potw[k] - 1)) - 1;
                lo = -(1 << (m_potw[k] - 1));
                s = m_v[k] + d;
                if (s > hi) s = hi;
                if (s < lo) s = lo;
                if (s > 0) s = (s > m_leak[k]) ? s - m_leak[k] : 0;
                else if (s < 0) s = (-s > m_leak[k]) ? s + m_leak[k] : 0;
                if (m_th[k] != 0 && s >= m_th[k]) begin
                    m_spk[k] = 1; m_v[k] = 0; m_refr[k] = 2;
                end else begin
                    m_v[k] = s;
                end
            end
            if (cfg_w_we && cfg_nrn == 1'b0) begin
                wv = int'(cfg_w);
                if (wv > 7) wv = wv - 16;
                m_w[k][cfg_syn] = wv;
            end
            if (cfg_th_we && cfg_nrn == 1'b0) m_th[k] = int'(cfg_th) & m_thmask[k];
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("a_spike", int'(spk_a), m_spk[0]);
        chk("a_pot", int'($signed(pot_a)), m_v[0]);
        chk("b_spike", int'(spk_b), m_spk[1]);
        chk("b_pot", int'($signed(pot_b)), m_v[1]);
        chk("c_spike", int'(spk_c), m_spk[2]);
        chk("c_pot", int'($signed(pot_c)), m_v[2]);
    endtask

    // One clock: DUT and model both consume the current inputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 0; clr = 0; cfg_w_we = 0; cfg_th_we = 0;
        cfg_nrn = '0; cfg_syn = '0; cfg_w = '0; cfg_th = '0;
        p_in = '0; n_in = '0;
    endtask

    // ---------------- directed vector table (instance A) ----------------
    typedef struct {
        logic       r, c, wwe, twe;
        logic [0:0] nrn, syn;
        logic [3:0] w;
        logic [7:0] th;
        logic [1:0] p, n;
        int         es, ep;
    } vec_t;

    vec_t vec[38];

    function automatic vec_t mk(input int r, input int c, input int wwe, input int nrn,
                                input int syn, input int w, input int twe, input int th,
                                input int p, input int n, input int es, input int ep);
        vec_t v;
        v.r = 1'(r); v.c = 1'(c); v.wwe = 1'(wwe); v.nrn = 1'(nrn); v.syn = 1'(syn);
        v.w = 4'(w); v.twe = 1'(twe); v.th = 8'(th); v.p = 2'(p); v.n = 2'(n);
        v.es = es; v.ep = ep;
        return v;
    endfunction

    initial begin
        // AND config: w=1/1, th=4
        vec[0]  = mk(0,0, 0,0,0,0,  0,0, 3,0, 0, 2);
        vec[1]  = mk(0,0, 0,0,0,0,  0,0, 3,0, 1, 0);
        vec[2]  = mk(0,0, 0,0,0,0,  0,0, 0,0, 0, 0);
        vec[3]  = mk(0,0, 0,0,0,0,  0,0, 0,0, 0, 0);
        vec[4]  = mk(0,0, 0,0,0,0,  0,0, 1,2, 0, 0);
        vec[5]  = mk(0,0, 0,0,0,0,  0,0, 1,2, 0, 0);
        vec[6]  = mk(0,0, 0,0,0,0,  0,0, 1,0, 0, 1);
        vec[7]  = mk(0,0, 0,0,0,0,  0,0, 1,2, 0, 1);
        // th=2, continuous input: spike every 3 cycles, pot 0 while refractory
        vec[8]  = mk(0,0, 0,0,0,0,  1,2, 0,0, 0, 1);
        vec[9]  = mk(0,0, 0,0,0,0,  0,0, 3,0, 1, 0);
        vec[10] = mk(0,0, 0,0,0,0,  0,0, 3,0, 0, 0);
        vec[11] = mk(0,0, 0,0,0,0,  0,0, 3,0, 0, 0);
        vec[12] = mk(0,0, 0,0,0,0,  0,0, 3,0, 1, 0);
        vec[13] = mk(0,0, 0,0,0,0,  0,0, 3,0, 0, 0);
        vec[14] = mk(0,0, 0,0,0,0,  0,0, 3,0, 0, 0);
        vec[15] = mk(0,0, 0,0,0,0,  0,0, 3,0, 1, 0);
        vec[16] = mk(0,0, 0,0,0,0,  0,0, 0,0, 0, 0);
        vec[17] = mk(0,0, 0,0,0,0,  0,0, 0,0, 0, 0);
        vec[18] = mk(0,0, 0,0,0,0,  0,0, 0,0, 0, 0);
        // w[0][1] = -3 written alongside a p_in[1] spike: old weight used first
        vec[19] = mk(0,0, 1,0,1,13, 0,0, 2,0, 0, 1);
        vec[20] = mk(0,0, 0,0,0,0,  0,0, 2,0, 0, -2);
        // out-of-range neuron writes are dropped
        vec[21] = mk(0,0, 1,1,0,5,  0,0, 1,0, 0, -1);
        vec[22] = mk(0,0, 0,0,0,0,  0,0, 1,0, 0, 0);
        vec[23] = mk(0,0, 0,1,0,0,  1,1, 1,0, 0, 1);
        vec[24] = mk(0,0, 0,0,0,0,  0,0, 1,0, 1, 0);
        vec[25] = mk(0,0, 0,0,0,0,  0,0, 0,0, 0, 0);
        vec[26] = mk(0,0, 0,0,0,0,  0,0, 0,0, 0, 0);
        // th back to 4, build pot to 3, then clr with input active
        vec[27] = mk(0,0, 0,0,0,0,  1,4, 1,0, 0, 1);
        vec[28] = mk(0,0, 0,0,0,0,  0,0, 1,0, 0, 2);
        vec[29] = mk(0,0, 0,0,0,0,  0,0, 1,0, 0, 3);
        vec[30] = mk(0,1, 0,0,0,0,  0,0, 1,0, 0, 0);
        vec[31] = mk(0,0, 0,0,0,0,  0,0, 1,0, 0, 1);
        vec[32] = mk(0,0, 0,0,0,0,  0,0, 2,0, 0, -2);
        vec[33] = mk(0,0, 0,0,0,0,  0,0, 1,2, 0, 2);
        vec[34] = mk(0,0, 0,0,0,0,  0,0, 1,0, 0, 3);
        // rst at pot=3: weights/threshold return to 1/1, 4
        vec[35] = mk(1,0, 0,0,0,0,  0,0, 3,0, 0, 0);
        vec[36] = mk(0,0, 0,0,0,0,  0,0, 3,0, 0, 2);
        vec[37] = mk(0,0, 0,0,0,0,  0,0, 3,0, 1, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        chk("reset_spike", int'(spk_a), 0);
        chk("reset_pot", int'(pot_a), 0);

        for (int r = 0; r < 38; r++) begin
            rst = vec[r].r; clr = vec[r].c;
            cfg_w_we = vec[r].wwe; cfg_nrn = vec[r].nrn; cfg_syn = vec[r].syn; cfg_w = vec[r].w;
            cfg_th_we = vec[r].twe; cfg_th = vec[r].th;
            p_in = vec[r].p; n_in = vec[r].n;
            tick();
            chk($sformatf("vec%0d_spike", r), int'(spk_a), vec[r].es);
            chk($sformatf("vec%0d_pot", r), int'($signed(pot_a)), vec[r].ep);
        end

        // Leak on instance B: w[0]=3 -> 2, 1, 0, 0 then -2, -1, 0
        idle_inputs();
        rst = 1; tick(); rst = 0;
        cfg_w_we = 1; cfg_syn = 0; cfg_w = 4'd3; tick(); idle_inputs();
        p_in = 2'b01; tick(); p_in = 2'b00;
        chk("leak_pos0", int'($signed(pot_b)), 2);
        tick(); chk("leak_pos1", int'($signed(pot_b)), 1);
        tick(); chk("leak_pos2", int'($signed(pot_b)), 0);
        tick(); chk("leak_hold", int'($signed(pot_b)), 0);
        chk("leak_nospike", int'(spk_b), 0);
        n_in = 2'b01; tick(); n_in = 2'b00;
        chk("leak_neg0", int'($signed(pot_b)), -2);
        tick(); chk("leak_neg1", int'($signed(pot_b)), -1);
        tick(); chk("leak_neg2", int'($signed(pot_b)), 0);

        // Saturation on instance C: th=0, w=7/7, clamp at 31 then -32
        idle_inputs();
        cfg_th_we = 1; cfg_th = 8'd0; cfg_w_we = 1; cfg_syn = 0; cfg_w = 4'd7; tick();
        idle_inputs();
        cfg_w_we = 1; cfg_syn = 1; cfg_w = 4'd7; tick();
        idle_inputs();
        p_in = 2'b11;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("sat_nospike", int'(spk_c), 0);
        end
        chk("sat_hi", int'($signed(pot_c)), 31);
        p_in = 2'b00; n_in = 2'b11;
        for (int c = 0; c < 6; c++) tick();
        chk("sat_lo", int'($signed(pot_c)), -32);
        tick();
        chk("sat_lo_hold", int'($signed(pot_c)), -32);

        // Randomized traffic against the model
        idle_inputs();
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 800; c++) begin
            p_in      = 2'($urandom_range(0, 3));
            n_in      = 2'($urandom_range(0, 3));
            cfg_w_we  = ($urandom_range(0, 7) == 0);
            cfg_th_we = ($urandom_range(0, 9) == 0);
            cfg_nrn   = 1'($urandom_range(0, 3) == 0);
            cfg_syn   = 1'($urandom_range(0, 1));
            cfg_w     = 4'($urandom_range(0, 15));
            cfg_th    = 8'($urandom_range(0, 12));
            clr       = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
